// File: rtl/divider_64bit_pkg.sv
// Shared processor definitions for the iterative divider.
//   DATA_WIDTH        - default operand/result width
//   DIV_ZERO_QUOTIENT - quotient reported for a zero divisor (all ones)
//   div_state_t       - divider FSM states
package divider_64bit_pkg;

  localparam int DATA_WIDTH = 64;

  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_64bit_step.sv
// One restoring shift-subtract iteration (combinational).
//   rem_in  - partial remainder (WIDTH+1 bits)
//   dvd_bit - next dividend bit shifted into the remainder
//   dvs     - divisor magnitude
//   rem_out - updated partial remainder
//   q_bit   - quotient bit produced by this iteration
module restoring_div_step
  import divider_64bit_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  always_comb begin
    // The restored remainder is always below the divisor, so rem_in[WIDTH]
    // is zero and this subtraction equals the WIDTH+1-bit trial; the extra
    // bit only serves as the sign of the result.
    trial   = {rem_in, dvd_bit} - {2'b00, dvs};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : {rem_in[WIDTH-1:0], dvd_bit};
  end

endmodule

// File: rtl/divider_64bit.sv
// Iterative signed/unsigned integer divider, one quotient bit per clock.
//   clk, reset          - clock, asynchronous active-high reset
//   start               - request a division (accepted only when idle)
//   signed_op           - 1 = two's-complement operands, 0 = unsigned
//   dividend, divisor   - operands, sampled with start
//   busy                - division in progress
//   done                - one-cycle pulse when results update
//   quotient, remainder - registered results, held until the next done
//   div_by_zero         - divisor was zero for the latest result
module divider_64bit
  import divider_64bit_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;      // dividend bits still to consume, quotient bits shifted in from the LSB
  logic [WIDTH-1:0] dvs;
  logic             q_neg, r_neg;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_mag;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_mag = {dvd[WIDTH-2:0], step_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      DIV_IDLE: if (start) next_state = (divisor == '0) ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        busy = 1'b1;
        if (count == '0) next_state = DIV_DONE;
      end
      DIV_DONE: begin
        done       = 1'b1;
        next_state = DIV_IDLE;
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd   <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
              dvs   <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
              q_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg <= signed_op & dividend[WIDTH-1];
              rem   <= '0;
              count <= CW'(WIDTH - 1);
            end
          end
        end
        DIV_RUN: begin
          rem   <= step_rem;
          dvd   <= q_mag;
          count <= count - 1'b1;
          if (count == '0) begin
            quotient    <= q_neg ? -q_mag : q_mag;
            remainder   <= r_neg ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_64bit.md
# divider_64bit

Iterative 64-bit integer divider for the processor model's execution stage, the inverse companion to the combinational adder/subtractor. It produces quotient and remainder by restoring shift-subtract, one quotient bit per clock, for signed or unsigned operands. A start/done handshake lets the control unit stall the pipeline while `busy` is high.

## Interface

**Parameters**

- `WIDTH`, 64, operand and result width in bits.

**Ports**

- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-high; clears all state and outputs.
- `start`, in, 1, request a division; sampled only in IDLE.
- `signed_op`, in, 1, 1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `dividend`, in, WIDTH, numerator; sampled with `start`.
- `divisor`, in, WIDTH, denominator; sampled with `start`.
- `busy`, out, 1, high while a division is in progress (RUN).
- `done`, out, 1, one-cycle pulse; results are valid from this cycle onward.
- `quotient`, out, WIDTH, registered result; held until the next `done`.
- `remainder`, out, WIDTH, registered result; held until the next `done`.
- `div_by_zero`, out, 1, set with `done` when divisor was 0; held until the next `done`.

## Operation

- **FSM states:** IDLE, RUN, DONE.
  - IDLE to RUN: `start` = 1 and `divisor` != 0.
  - IDLE to DONE: `start` = 1 and `divisor` == 0.
  - RUN to DONE: the final iteration (counter == 0).
  - DONE to IDLE: unconditionally, after one cycle.
- **Operand capture at start:**
  - Latch magnitudes: if `signed_op` = 1 and an operand's MSB = 1, store its two's-complement negation; otherwise store it unchanged.
  - Record `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend). Both are forced to 0 when unsigned.
  - Clear the partial remainder (WIDTH+1 bits). Set the counter to WIDTH-1.
- **Each RUN cycle:**
  - Compute trial = {rem[WIDTH-1:0], dvd_msb} − {1'b0, dvs}.
  - If trial is non-negative: rem ← trial, and shift a 1 into the quotient.
  - Otherwise: rem ← the shifted value, and shift a 0 into the quotient.
  - Decrement the counter.
- **On the final iteration edge:** register `quotient` (negated if `q_neg`) and `remainder` (negated if `r_neg`), clear `div_by_zero`, and set `done`.
- **Divide by zero:** `quotient` = all ones, `remainder` = the original `dividend` (unmodified, regardless of `signed_op`), `div_by_zero` = 1.
- **Signed overflow (most-negative / −1):** the natural result is `quotient` = 0x8000_0000_0000_0000 and `remainder` = 0. No flag is raised.
- **Starts outside IDLE:** `start` in RUN or DONE is ignored. No queueing.
- **Reset:** asserting `reset` at any time, including mid-RUN, returns to IDLE. All outputs go to 0 and no `done` is produced for the aborted operation.

## Timing

- **Reset values:** `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, state = IDLE.
- **Normal latency:** with `start` sampled at edge E0, `busy` is high after E0 through E64. `done` is high for exactly one cycle after E64, i.e. `done` rises WIDTH edges after the start edge.
- **Divide-by-zero latency:** `done` is high in the cycle after E0 and `busy` never asserts.
- **Back-to-back throughput:** the earliest next accepted `start` is in the cycle after `done`, i.e. one result per WIDTH+2 cycles.
- **Output stability:** `quotient`, `remainder` and `div_by_zero` change only on the edge that sets `done` (or on reset).
- **Combinational paths:** none from inputs to outputs.

## Structure

- **Shared processor definitions package/header:**
  - FSM state encodings (`DIV_IDLE`, `DIV_RUN`, `DIV_DONE`).
  - Default width constant `DATA_WIDTH` = 64.
  - Divide-by-zero quotient constant (all ones).
- **Sub-module `restoring_div_step`:** combinational single-iteration shift-subtract.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder and quotient bit.
- **`divider_64bit` itself:** holds the FSM, counter, operand and sign registers, and the final sign-fixup negations.

## Test plan

- **Unsigned basic:** `signed_op` = 0, 100 / 7 → `quotient` = 14, `remainder` = 2. `busy` is high for 64 cycles and `done` pulses once, 64 edges after start.
- **Signed signs:** −100 / 7 → −14 rem −2; 100 / −7 → −14 rem 2; −100 / −7 → 14 rem −2.
- **Divide by zero:** dividend = 0x1234, divisor = 0 → `quotient` = 0xFFFF_FFFF_FFFF_FFFF, `remainder` = 0x1234, `div_by_zero` = 1. `done` comes one cycle after start and `busy` stays 0.
- **Overflow and full width:**
  - Signed 0x8000_0000_0000_0000 / −1 → `quotient` = 0x8000_0000_0000_0000, `remainder` = 0.
  - Unsigned 0xFFFF_FFFF_FFFF_FFFF / 1 → `quotient` = all ones, `remainder` = 0.
- **Ignored start:** assert `start` with new operands at cycle 10 of RUN → the original result is unchanged, with a single `done` only.
- **Reset mid-operation:** assert `reset` at cycle 30 of RUN → all outputs are 0 immediately (asynchronous), no `done` follows, and a new 50 / 5 afterwards yields 10 rem 0.
